// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS32 program counter and instruction-fetch handshake
// Holds pc, picks the next-PC source and runs the IDLE/REQ/DONE fetch sequence.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic        flush_pend_q, flush_pend_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        load_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      instr_q      <= 32'h0;
      flush_addr_q <= 32'h0;
      flush_pend_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      flush_addr_q <= flush_addr_d;
      flush_pend_q <= flush_pend_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_comb begin
    seq_pc       = pc_q + 32'd4;
    br_target    = seq_pc + br_offset;
    jump_target  = {seq_pc[31:28], jump_index, 2'b00};
    state_d      = state_q;
    instr_d      = instr_q;
    flush_addr_d = flush_addr_q;
    flush_pend_d = flush_pend_q;
    target       = seq_pc;
    load_pc      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (flush) begin
          target  = flush_addr;
          load_pc = 1'b1;
        end
      end

      REQ: begin
        // The outstanding request always completes; a flush only redirects
        // once the ack retires it, and the returned word is dropped.
        if (imem_ack) begin
          if (flush || flush_pend_q) begin
            target       = flush ? flush_addr : flush_addr_q;
            load_pc      = 1'b1;
            flush_pend_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            state_d = DONE;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
          flush_addr_d = flush_addr;
        end
      end

      DONE: begin
        if (flush) begin
          target  = flush_addr;
          load_pc = 1'b1;
          state_d = REQ;
        end else if (!stall) begin
          if (jr)            target = jr_target;
          else if (jump)     target = jump_target;
          else if (br_taken) target = br_target;
          else               target = seq_pc;
          load_pc = 1'b1;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    pc_d       = load_pc ? {target[31:2], 2'b00} : pc_q;
    addr_err_d = load_pc && (target[1:0] != 2'b00);
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == DONE);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
// An imem model answers after wait_cycles request cycles with rdata = ~addr.

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall;
  logic        flush;
  logic [31:0] flush_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int errors = 0;
  int checks = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  int ack_count = 0;
  int ack_base;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .stall(stall), .flush(flush), .flush_addr(flush_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .instr(instr), .pc(pc),
    .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (wcnt == wait_cycles) begin
      imem_ack   = 1'b1;
      imem_rdata = ~imem_addr;
      ack_count  = ack_count + 1;
      wcnt       = 0;
    end else begin
      imem_ack = 1'b0;
      wcnt     = wcnt + 1;
    end
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic deliver(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!fetch_valid && n < 30) begin
      step();
      n++;
    end
    check32({tag, " valid"}, {31'b0, fetch_valid}, 32'd1);
    check32({tag, " pc"}, pc, exp_pc);
    check32({tag, " instr"}, instr, ~exp_pc);
    check32({tag, " pc_plus4"}, pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; br_taken = 1'b0; br_offset = 32'h0; jump = 1'b0; jump_index = 26'h0;
    jr = 1'b0; jr_target = 32'h0; stall = 1'b0; flush = 1'b0; flush_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) step();
    check32("rst imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check32("rst addr_err", {31'b0, addr_err}, 32'd0);
    check32("rst instr", instr, 32'h0);
    check32("rst pc", pc, 32'h0);
    rst_n = 1'b1;

    deliver("seq0", 32'h0);
    step();
    check32("seq gap valid", {31'b0, fetch_valid}, 32'd0);
    check32("seq gap req", {31'b0, imem_req}, 32'd1);
    check32("seq gap addr", imem_addr, 32'h4);
    step();
    check32("seq1 valid now", {31'b0, fetch_valid}, 32'd1);
    deliver("seq1", 32'h4);
    step();
    step();
    deliver("seq2", 32'h8);

    flush = 1'b1; flush_addr = 32'h100;
    step();
    flush = 1'b0;
    check32("flush done valid", {31'b0, fetch_valid}, 32'd0);
    check32("flush done addr", imem_addr, 32'h100);
    deliver("at100", 32'h100);

    br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
    step();
    br_taken = 1'b0;
    check32("branch back addr", imem_addr, 32'hF4);
    deliver("atF4", 32'hF4);

    flush = 1'b1; flush_addr = 32'h1000_0010;
    step();
    flush = 1'b0;
    deliver("at10000010", 32'h1000_0010);
    jump = 1'b1; jump_index = 26'h40; br_taken = 1'b1; br_offset = 32'h40;
    step();
    jump = 1'b0; br_taken = 1'b0;
    check32("jump over br addr", imem_addr, 32'h1000_0100);
    deliver("at10000100", 32'h1000_0100);

    jr = 1'b1; jr_target = 32'h2000; jump = 1'b1;
    step();
    jr = 1'b0; jump = 1'b0;
    check32("jr over jump addr", imem_addr, 32'h2000);
    deliver("at2000", 32'h2000);

    stall = 1'b1; br_taken = 1'b1; br_offset = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check32("stall valid", {31'b0, fetch_valid}, 32'd1);
      check32("stall pc", pc, 32'h2000);
      check32("stall instr", instr, ~32'h2000);
      check32("stall req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    br_taken = 1'b0;
    check32("stall release addr", imem_addr, 32'h2014);
    deliver("at2014", 32'h2014);

    jr = 1'b1; jr_target = 32'h203;
    step();
    jr = 1'b0;
    check32("misalign err", {31'b0, addr_err}, 32'd1);
    check32("misalign addr", imem_addr, 32'h200);
    step();
    check32("misalign err pulse", {31'b0, addr_err}, 32'd0);
    deliver("at200", 32'h200);

    flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    deliver("atFFFFFFFC", 32'hFFFF_FFFC);
    step();
    check32("wrap addr", imem_addr, 32'h0);
    deliver("wrap0", 32'h0);

    wait_cycles = 4;
    step();
    check32("slow req addr", imem_addr, 32'h4);
    ack_base = ack_count;
    flush = 1'b1; flush_addr = 32'h180;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check32("pend addr held", imem_addr, 32'h4);
      check32("pend no valid", {31'b0, fetch_valid}, 32'd0);
      step();
    end
    deliver("at180", 32'h180);
    check32("pend ack count", ack_count - ack_base, 32'd2);
    wait_cycles = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
